lcd_refresh_ctrl: RTL and testbench

Sequencer that owns the HD44780-compatible character LCD bus. After power-up it runs the LCD init command list. It then keeps the display coherent with two inputs: the 3-char mode tag from the top-line mapper and a 16-char bottom line from the value formatter. Whenever either input changes, or a refresh is forced, it rewrites both lines with correct enable-pulse and settle timing.

---
 rtl/lcd_pkg.sv | 32 +++
 rtl/lcd_byte_writer.sv | 104 ++++++++++
 rtl/lcd_refresh_ctrl.sv | 171 +++++++++++++++++
 tb/tb_lcd_refresh_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared constants for the HD44780 character LCD refresh sequencer.
package lcd_pkg;

    localparam logic [7:0] CMD_FUNC    = 8'h38;
    localparam logic [7:0] CMD_DISP_ON = 8'h0C;
    localparam logic [7:0] CMD_ENTRY   = 8'h06;
    localparam logic [7:0] CMD_CLEAR   = 8'h01;
    localparam logic [7:0] CMD_LINE0   = 8'h80;
    localparam logic [7:0] CMD_LINE1   = 8'hC0;
    localparam logic [7:0] CHAR_BLANK  = 8'hFE;

    localparam logic [2:0] ST_PWR  = 3'd0;
    localparam logic [2:0] ST_INIT = 3'd1;
    localparam logic [2:0] ST_IDLE = 3'd2;
    localparam logic [2:0] ST_TOPA = 3'd3;
    localparam logic [2:0] ST_TOPC = 3'd4;
    localparam logic [2:0] ST_BOTA = 3'd5;
    localparam logic [2:0] ST_BOTC = 3'd6;

    localparam int unsigned INIT_N = 5;

    // Power-up command list, in issue order.
    function automatic logic [7:0] init_cmd(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1: init_cmd = CMD_FUNC;
            3'd2:       init_cmd = CMD_DISP_ON;
            3'd3:       init_cmd = CMD_ENTRY;
            default:    init_cmd = CMD_CLEAR;
        endcase
    endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// One LCD bus write: setup cycle, enable pulse, then settle wait.
// o_done_c flags the last settle cycle so the next start can follow back-to-back.
module lcd_byte_writer
    import lcd_pkg::*;
#(
    parameter int unsigned T_E   = 12,
    parameter int unsigned T_CMD = 2000,
    parameter int unsigned T_CLR = 82000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic [7:0] i_byte,
    input  logic       i_rs,
    output logic [7:0] o_data,
    output logic       o_rs,
    output logic       o_e,
    output logic       o_done_c
);

    localparam int unsigned T_W   = (T_CLR > T_CMD) ? T_CLR : T_CMD;
    localparam int unsigned T_MAX = (T_W > T_E) ? T_W : T_E;
    localparam int unsigned CW    = $clog2(T_MAX + 1);

    localparam logic [1:0] PH_IDLE   = 2'd0;
    localparam logic [1:0] PH_SETUP  = 2'd1;
    localparam logic [1:0] PH_E      = 2'd2;
    localparam logic [1:0] PH_SETTLE = 2'd3;

    logic [1:0]    r_phase, w_phase_n;
    logic [CW-1:0] r_cnt, w_cnt_n;
    logic          r_clr, w_clr_n;
    logic [7:0]    r_data, w_data_n;
    logic          r_rs, w_rs_n;
    logic          r_e, w_e_n;
    logic [CW-1:0] w_wait_last;
    logic          w_accept;

    assign w_wait_last = r_clr ? CW'(T_CLR - 1) : CW'(T_CMD - 1);
    assign o_done_c    = (r_phase == PH_SETTLE) && (r_cnt == w_wait_last);
    assign w_accept    = i_start && ((r_phase == PH_IDLE) || o_done_c);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_phase <= PH_IDLE;
            r_cnt   <= '0;
            r_clr   <= 1'b0;
            r_data  <= 8'h00;
            r_rs    <= 1'b0;
            r_e     <= 1'b0;
        end else begin
            r_phase <= w_phase_n;
            r_cnt   <= w_cnt_n;
            r_clr   <= w_clr_n;
            r_data  <= w_data_n;
            r_rs    <= w_rs_n;
            r_e     <= w_e_n;
        end
    end

    always_comb begin
        w_phase_n = r_phase;
        w_cnt_n   = r_cnt;
        w_clr_n   = r_clr;
        w_data_n  = r_data;
        w_rs_n    = r_rs;
        w_e_n     = r_e;
        case (r_phase)
            PH_SETUP: begin
                w_phase_n = PH_E;
                w_e_n     = 1'b1;
                w_cnt_n   = '0;
            end
            PH_E: begin
                if (r_cnt == CW'(T_E - 1)) begin
                    w_phase_n = PH_SETTLE;
                    w_e_n     = 1'b0;
                    w_cnt_n   = '0;
                end else begin
                    w_cnt_n = r_cnt + CW'(1);
                end
            end
            PH_SETTLE: begin
                if (o_done_c) w_phase_n = PH_IDLE;
                else          w_cnt_n   = r_cnt + CW'(1);
            end
            default: ;
        endcase
        // Data and rs are only replaced when a new write is accepted.
        if (w_accept) begin
            w_phase_n = PH_SETUP;
            w_cnt_n   = '0;
            w_data_n  = i_byte;
            w_rs_n    = i_rs;
            w_clr_n   = !i_rs && (i_byte == CMD_CLEAR);
            w_e_n     = 1'b0;
        end
    end

    assign o_data = r_data;
    assign o_rs   = r_rs;
    assign o_e    = r_e;

endmodule

// File: rtl/lcd_refresh_ctrl.sv
// Owns the LCD bus: power-up wait, init list, then full two-line rewrites
// whenever the mode tag or bottom line changes or a refresh is forced.
module lcd_refresh_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned T_PWR = 750000,
    parameter int unsigned T_E   = 12,
    parameter int unsigned T_CMD = 2000,
    parameter int unsigned T_CLR = 82000,
    parameter int unsigned BOT_N = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [23:0]        top_chac,
    input  logic [8*BOT_N-1:0] bot_chac,
    input  logic               force_refresh,
    output logic [7:0]         lcd_data,
    output logic               lcd_rs,
    output logic               lcd_rw,
    output logic               lcd_e,
    output logic               ready,
    output logic               refresh_done
);

    localparam int unsigned WW  = $clog2(((T_PWR > T_CLR) ? T_PWR : T_CLR) + 1);
    localparam int unsigned IW  = ($clog2(BOT_N) < 3) ? 3 : $clog2(BOT_N);
    localparam int unsigned BW  = 8 * BOT_N;
    localparam int unsigned BIW = $clog2(BW);

    logic [2:0]     r_state, w_state_n;
    logic [WW-1:0]  r_wait, w_wait_n;
    logic [IW-1:0]  r_idx, w_idx_n, w_idx_inc;
    logic           r_pending, w_pend_n;
    logic [23:0]    r_top_snap;
    logic [BW-1:0]  r_bot_snap;
    logic           r_ready, r_done, w_done_n;
    logic           w_start_c, w_rs, w_snap, w_after_init, w_diff, w_wr_done;
    logic [7:0]     w_byte, w_top_nx;
    logic [BIW-1:0] w_bot_lsb;

    assign w_idx_inc = r_idx + IW'(1);
    assign w_top_nx  = (w_idx_inc[1:0] == 2'd1) ? r_top_snap[15:8] : r_top_snap[7:0];
    assign w_bot_lsb = BIW'(BW - 8) - BIW'({w_idx_inc, 3'b000});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_PWR;
            r_wait     <= '0;
            r_idx      <= '0;
            r_pending  <= 1'b1;
            r_top_snap <= {3{CHAR_BLANK}};
            r_bot_snap <= {BOT_N{CHAR_BLANK}};
            r_ready    <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_wait    <= w_wait_n;
            r_idx     <= w_idx_n;
            r_pending <= w_pend_n;
            r_ready   <= (w_state_n == ST_IDLE) && !w_pend_n;
            r_done    <= w_done_n;
            if (w_snap) begin
                r_top_snap <= top_chac;
                r_bot_snap <= bot_chac;
            end
        end
    end

    // r_idx always names the byte currently in flight within the segment.
    always_comb begin
        w_state_n = r_state;
        w_wait_n  = r_wait;
        w_idx_n   = r_idx;
        w_start_c = 1'b0;
        w_byte    = 8'h00;
        w_rs      = 1'b0;
        w_done_n  = 1'b0;
        w_snap    = 1'b0;
        case (r_state)
            ST_PWR: begin
                if (r_wait == WW'(T_PWR - 1)) begin
                    w_state_n = ST_INIT;
                    w_start_c = 1'b1;
                    w_byte    = init_cmd(3'd0);
                    w_idx_n   = '0;
                end else begin
                    w_wait_n = r_wait + WW'(1);
                end
            end
            ST_INIT: if (w_wr_done) begin
                if (r_idx == IW'(INIT_N - 1)) begin
                    w_state_n = ST_IDLE;
                end else begin
                    w_start_c = 1'b1;
                    w_byte    = init_cmd(w_idx_inc[2:0]);
                    w_idx_n   = w_idx_inc;
                end
            end
            ST_IDLE: if (r_pending) begin
                w_snap    = 1'b1;
                w_state_n = ST_TOPA;
                w_start_c = 1'b1;
                w_byte    = CMD_LINE0;
            end
            ST_TOPA: if (w_wr_done) begin
                w_state_n = ST_TOPC;
                w_start_c = 1'b1;
                w_rs      = 1'b1;
                w_byte    = r_top_snap[23:16];
                w_idx_n   = '0;
            end
            ST_TOPC: if (w_wr_done) begin
                w_start_c = 1'b1;
                if (r_idx == IW'(2)) begin
                    w_state_n = ST_BOTA;
                    w_byte    = CMD_LINE1;
                end else begin
                    w_rs    = 1'b1;
                    w_byte  = w_top_nx;
                    w_idx_n = w_idx_inc;
                end
            end
            ST_BOTA: if (w_wr_done) begin
                w_state_n = ST_BOTC;
                w_start_c = 1'b1;
                w_rs      = 1'b1;
                w_byte    = r_bot_snap[BW-1 -: 8];
                w_idx_n   = '0;
            end
            ST_BOTC: if (w_wr_done) begin
                if (r_idx == IW'(BOT_N - 1)) begin
                    w_state_n = ST_IDLE;
                    w_done_n  = 1'b1;
                end else begin
                    w_start_c = 1'b1;
                    w_rs      = 1'b1;
                    w_byte    = r_bot_snap[w_bot_lsb +: 8];
                    w_idx_n   = w_idx_inc;
                end
            end
            default: w_state_n = ST_PWR;
        endcase

        // Taking the snapshot absorbs any event seen in the same cycle.
        w_after_init = (r_state != ST_PWR) && (r_state != ST_INIT);
        w_diff       = (top_chac != r_top_snap) || (bot_chac != r_bot_snap);
        if (w_snap) w_pend_n = 1'b0;
        else        w_pend_n = r_pending || force_refresh || (w_after_init && w_diff);
    end

    lcd_byte_writer #(
        .T_E   (T_E),
        .T_CMD (T_CMD),
        .T_CLR (T_CLR)
    ) u_writer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_start_c),
        .i_byte   (w_byte),
        .i_rs     (w_rs),
        .o_data   (lcd_data),
        .o_rs     (lcd_rs),
        .o_e      (lcd_e),
        .o_done_c (w_wr_done)
    );

    assign lcd_rw       = 1'b0;
    assign ready        = r_ready;
    assign refresh_done = r_done;

endmodule

// File: tb/tb_lcd_refresh_ctrl.sv
// Randomized bench for lcd_refresh_ctrl against a cycle-scheduled byte-stream model.
module tb_lcd_refresh_ctrl;

    localparam int T_PWR = 20;
    localparam int T_E   = 2;
    localparam int T_CMD = 5;
    localparam int T_CLR = 10;
    localparam int BOT_N = 16;
    localparam int BW    = 8 * BOT_N;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [23:0]   top_chac;
    logic [BW-1:0] bot_chac;
    logic          force_refresh;
    logic [7:0]    lcd_data;
    logic          lcd_rs, lcd_rw, lcd_e, ready, refresh_done;

    always #5 clk = ~clk;

    lcd_refresh_ctrl #(
        .T_PWR (T_PWR), .T_E (T_E), .T_CMD (T_CMD), .T_CLR (T_CLR), .BOT_N (BOT_N)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .top_chac      (top_chac),
        .bot_chac      (bot_chac),
        .force_refresh (force_refresh),
        .lcd_data      (lcd_data),
        .lcd_rs        (lcd_rs),
        .lcd_rw        (lcd_rw),
        .lcd_e         (lcd_e),
        .ready         (ready),
        .refresh_done  (refresh_done)
    );

    typedef struct {
        int         t;
        logic       rs;
        logic [7:0] d;
    } wr_t;

    wr_t           m_q[$];
    int            m_c, m_busy, m_done_at, m_cur_t, m_init_end;
    logic [7:0]    m_cur_d;
    logic          m_cur_rs, m_pend, m_last_e;
    logic [23:0]   m_top;
    logic [BW-1:0] m_bot;

    logic          nx_rst, nx_force;
    logic [23:0]   nx_top;
    logic [BW-1:0] nx_bot;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, m_c, act, exp);
        end
    endtask

    // Schedule one write at cycle t and advance t by its full byte period.
    task automatic push_byte(inout int t, input logic rs, input logic [7:0] d);
        wr_t w;
        w.t = t; w.rs = rs; w.d = d;
        m_q.push_back(w);
        t += 1 + T_E + ((!rs && d == 8'h01) ? T_CLR : T_CMD);
    endtask

    task automatic model_reset();
        int t;
        logic [7:0] cmds [5];
        cmds = '{8'h38, 8'h38, 8'h0C, 8'h06, 8'h01};
        m_q.delete();
        m_c = 0; m_cur_t = -1000; m_cur_d = 8'h00; m_cur_rs = 1'b0;
        m_pend = 1'b1; m_done_at = -1; m_top = '0; m_bot = '0;
        t = T_PWR;
        for (int i = 0; i < 5; i++) push_byte(t, 1'b0, cmds[i]);
        m_busy = t;
        m_init_end = t;
    endtask

    task automatic model_frame(input int c0);
        int t;
        t = c0;
        push_byte(t, 1'b0, 8'h80);
        for (int k = 0; k < 3; k++) push_byte(t, 1'b1, m_top[23 - 8*k -: 8]);
        push_byte(t, 1'b0, 8'hC0);
        for (int k = 0; k < BOT_N; k++) push_byte(t, 1'b1, m_bot[BW - 1 - 8*k -: 8]);
        m_busy = t;
        m_done_at = t;
    endtask

    // One clock cycle: drive inputs, compare outputs, advance the model.
    task automatic step();
        logic exp_e;
        @(negedge clk);
        rst_n = nx_rst; top_chac = nx_top; bot_chac = nx_bot; force_refresh = nx_force;
        nx_force = 1'b0;
        if (m_q.size() > 0 && m_q[0].t == m_c) begin
            m_cur_t = m_q[0].t; m_cur_rs = m_q[0].rs; m_cur_d = m_q[0].d;
            void'(m_q.pop_front());
        end
        exp_e = (m_c > m_cur_t) && (m_c <= m_cur_t + T_E);
        check_eq("lcd_data", 32'(lcd_data), 32'(m_cur_d));
        check_eq("lcd_rs", 32'(lcd_rs), 32'(m_cur_rs));
        check_eq("lcd_e", 32'(lcd_e), 32'(exp_e));
        check_eq("lcd_rw", 32'(lcd_rw), 32'd0);
        check_eq("ready", 32'(ready), 32'(m_c >= m_busy && !m_pend));
        check_eq("refresh_done", 32'(refresh_done), 32'(m_c == m_done_at));
        m_last_e = exp_e;
        if (!rst_n) begin
            model_reset();
        end else begin
            if (m_c >= m_busy && m_pend) begin
                m_top = top_chac; m_bot = bot_chac; m_pend = 1'b0;
                model_frame(m_c + 1);
            end else begin
                m_pend = m_pend || force_refresh ||
                         (m_c >= m_init_end && (top_chac != m_top || bot_chac != m_bot));
            end
            m_c++;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_until_ready(input int budget);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            step();
            if (ready === 1'b1 && m_q.size() == 0 && !m_pend) hit = 1'b1;
        end
        check_eq("ready_within_budget", 32'(hit), 32'd1);
    endtask

    initial begin
        bit found;
        nx_rst = 1'b0; nx_force = 1'b0;
        nx_top = 24'h413AFE; nx_bot = {BOT_N{8'h30}};
        rst_n = 1'b0; top_chac = nx_top; bot_chac = nx_bot; force_refresh = 1'b0;
        repeat (3) @(negedge clk);
        model_reset();
        run(2);
        nx_rst = 1'b1;
        run_until_ready(400);
        run(10);

        nx_top = 24'h423FFE;
        run_until_ready(400);
        run(5);

        // Several events inside one frame collapse into one follow-up frame.
        nx_force = 1'b1;
        run(30);
        nx_top = 24'h4C4D4E;
        run(40);
        nx_top = 24'h505152;
        run(15);
        nx_force = 1'b1;
        run_until_ready(600);
        run(5);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 149) == 0) nx_top = 24'($urandom);
            if ($urandom_range(0, 199) == 0) nx_bot[8*$urandom_range(0, BOT_N-1) +: 8] = 8'($urandom);
            if ($urandom_range(0, 299) == 0) nx_force = 1'b1;
            if (i == 100) nx_bot[7:0] = 8'h01;
            step();
        end
        run_until_ready(800);

        // Reset pulse while lcd_e is high in the middle of a frame.
        nx_force = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            step();
            if (m_last_e && (m_c - 1 == m_cur_t + 1) && m_busy > m_init_end) found = 1'b1;
        end
        check_eq("found_e_high", 32'(found), 32'd1);
        nx_rst = 1'b0;
        step();
        nx_rst = 1'b1;
        run_until_ready(500);
        run(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
